// File: rtl/rs544_pkg.sv
// rs544_pkg: shared constants, FSM state encoding and correction-event record
// for the RS(544,522) correction-apply stage.
package rs544_pkg;

  localparam int W      = 10;   // symbol width
  localparam int T      = 11;   // max correctable symbols / event-store depth
  localparam int N      = 544;  // codeword length in symbols
  localparam int M      = 32;   // symbols per beat
  localparam int CYCLES = 17;   // beats per frame
  localparam int POS_W  = 10;   // event position width

  typedef enum logic [1:0] {IDLE, LOAD, CORR, OUT} state_t;

  // One stored correction: beat index, lane within the beat, XOR magnitude.
  typedef struct packed {
    logic [4:0]   beat;
    logic [4:0]   lane;
    logic [W-1:0] y;
  } evt_t;

endpackage

// File: rtl/rs_evt_store.sv
// rs_evt_store: T-entry correction-event register file.
// Ports:
//   clk, rst_n : clock, async active-low reset (clears the count only)
//   clr        : empty the store
//   push, evt  : append one event (ignored when full)
//   beat_idx   : beat currently being output
//   count/full : number of stored events / store holds T events
//   mask       : M x W XOR mask for beat_idx, lane L at bits [L*W +: W]
module rs_evt_store
  import rs544_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           push,
  input  evt_t           evt,
  input  logic [4:0]     beat_idx,
  output logic [3:0]     count,
  output logic           full,
  output logic [M*W-1:0] mask
);

  evt_t entry [T];

  assign full = (count == 4'(T));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (push && !full)
      count <= count + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (push && !full && !clr)
      entry[count] <= evt;
  end

  // Events hitting the same symbol accumulate by XOR.
  always_comb begin
    mask = '0;
    for (int i = 0; i < T; i++) begin
      if ((4'(i) < count) && (entry[i].beat == beat_idx))
        mask[int'(entry[i].lane)*W +: W] = mask[int'(entry[i].lane)*W +: W] ^ entry[i].y;
    end
  end

endmodule

// File: rtl/rs_corr_apply.sv
// rs_corr_apply: buffers a 544-symbol frame, collects Chien/Forney correction
// events, then streams the corrected (or, if uncorrectable, untouched) frame.
// Ports:
//   clk_i, rst_ni                     : clock, async active-low reset
//   in_valid_i/in_ready_o/in_start_i/in_last_i/in_data_i : input beats
//   fny_vld_i/fny_rdy_o/fny_pos_i/fny_y_i/fny_den_zero_i : correction events
//   exceed_i, done_i                  : error count > T, event stream complete
//   out_valid_o/out_ready_i/out_start_o/out_last_o/out_data_o : output beats
//   out_uncorr_o, n_corr_o            : per-frame status, held during OUT
//   fmt_err_o                         : one-cycle input framing-error pulse
//
// state | meaning
// IDLE  | waiting for a start beat
// LOAD  | writing beats 1..16 into the symbol buffer
// CORR  | accepting correction events until done_i
// OUT   | streaming 17 corrected beats under valid/ready
module rs_corr_apply
  import rs544_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_start_i,
  input  logic             in_last_i,
  input  logic [M*W-1:0]   in_data_i,
  input  logic             fny_vld_i,
  output logic             fny_rdy_o,
  input  logic [POS_W-1:0] fny_pos_i,
  input  logic [W-1:0]     fny_y_i,
  input  logic             fny_den_zero_i,
  input  logic             exceed_i,
  input  logic             done_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             out_start_o,
  output logic             out_last_o,
  output logic [M*W-1:0]   out_data_o,
  output logic             out_uncorr_o,
  output logic [3:0]       n_corr_o,
  output logic             fmt_err_o
);

  state_t         state, state_nxt;
  logic [4:0]     cnt, cnt_nxt;
  logic           uncorr, uncorr_nxt;
  logic           last_early, last_early_nxt;
  logic           fmt_nxt;
  logic           buf_we;
  logic [4:0]     buf_idx;
  logic           st_clr, st_push, st_full;
  logic [3:0]     st_count;
  logic [M*W-1:0] st_mask;
  logic [M*W-1:0] sym_buf [CYCLES];
  logic           in_acc, ev_acc, pos_ok;
  evt_t           ev;

  assign in_acc = in_valid_i && in_ready_o;
  assign ev_acc = fny_vld_i && fny_rdy_o;
  assign pos_ok = (fny_pos_i < POS_W'(N));

  // M = 32: beat = pos/32, lane = 31 - pos%32 (bitwise inverse of low 5 bits).
  assign ev.beat = fny_pos_i[9:5];
  assign ev.lane = ~fny_pos_i[4:0];
  assign ev.y    = fny_y_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    uncorr_nxt     = uncorr;
    last_early_nxt = last_early;
    fmt_nxt        = 1'b0;
    buf_we         = 1'b0;
    buf_idx        = cnt;
    st_clr         = 1'b0;
    st_push        = 1'b0;
    in_ready_o     = 1'b0;
    fny_rdy_o      = 1'b0;
    out_valid_o    = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_acc) begin
          if (in_start_i) begin
            buf_we         = 1'b1;
            buf_idx        = 5'd0;
            cnt_nxt        = 5'd1;
            last_early_nxt = in_last_i;
            state_nxt      = LOAD;
          end else begin
            fmt_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        in_ready_o = 1'b1;
        if (in_acc) begin
          buf_we = 1'b1;
          if (in_start_i) begin
            buf_idx        = 5'd0;
            cnt_nxt        = 5'd1;
            last_early_nxt = in_last_i;
            fmt_nxt        = 1'b1;
          end else if (cnt == 5'(CYCLES-1)) begin
            state_nxt  = CORR;
            st_clr     = 1'b1;
            uncorr_nxt = 1'b0;
            fmt_nxt    = !in_last_i || last_early;
          end else begin
            cnt_nxt = cnt + 5'd1;
            if (in_last_i)
              last_early_nxt = 1'b1;
          end
        end
      end
      CORR: begin
        fny_rdy_o = 1'b1;
        if (ev_acc) begin
          st_push = pos_ok && !st_full;
          if (!pos_ok || st_full || fny_den_zero_i)
            uncorr_nxt = 1'b1;
        end
        if (exceed_i)
          uncorr_nxt = 1'b1;
        if (done_i) begin
          state_nxt = OUT;
          cnt_nxt   = 5'd0;
        end
      end
      OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (cnt == 5'(CYCLES-1)) begin
            state_nxt = IDLE;
            cnt_nxt   = 5'd0;
          end else begin
            cnt_nxt = cnt + 5'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt        <= '0;
      uncorr     <= 1'b0;
      last_early <= 1'b0;
      fmt_err_o  <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      uncorr     <= uncorr_nxt;
      last_early <= last_early_nxt;
      fmt_err_o  <= fmt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (buf_we)
      sym_buf[buf_idx] <= in_data_i;
  end

  rs_evt_store u_store (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .clr      (st_clr),
    .push     (st_push),
    .evt      (ev),
    .beat_idx (cnt),
    .count    (st_count),
    .full     (st_full),
    .mask     (st_mask)
  );

  assign out_data_o   = (state == OUT) ? (sym_buf[cnt] ^ (uncorr ? '0 : st_mask)) : '0;
  assign out_start_o  = (state == OUT) && (cnt == 5'd0);
  assign out_last_o   = (state == OUT) && (cnt == 5'(CYCLES-1));
  assign out_uncorr_o = (state == OUT) && uncorr;
  assign n_corr_o     = ((state == OUT) && !uncorr) ? st_count : 4'd0;

endmodule

// File: tb/tb_rs_corr_apply.sv
module tb_rs_corr_apply;
  import rs544_pkg::*;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic             in_start_i = 1'b0;
  logic             in_last_i = 1'b0;
  logic [M*W-1:0]   in_data_i = '0;
  logic             fny_vld_i = 1'b0;
  logic             fny_rdy_o;
  logic [POS_W-1:0] fny_pos_i = '0;
  logic [W-1:0]     fny_y_i = '0;
  logic             fny_den_zero_i = 1'b0;
  logic             exceed_i = 1'b0;
  logic             done_i = 1'b0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b1;
  logic             out_start_o;
  logic             out_last_o;
  logic [M*W-1:0]   out_data_o;
  logic             out_uncorr_o;
  logic [3:0]       n_corr_o;
  logic             fmt_err_o;

  rs_corr_apply dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_start_i(in_start_i),
    .in_last_i(in_last_i), .in_data_i(in_data_i),
    .fny_vld_i(fny_vld_i), .fny_rdy_o(fny_rdy_o), .fny_pos_i(fny_pos_i),
    .fny_y_i(fny_y_i), .fny_den_zero_i(fny_den_zero_i),
    .exceed_i(exceed_i), .done_i(done_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_start_o(out_start_o),
    .out_last_o(out_last_o), .out_data_o(out_data_o), .out_uncorr_o(out_uncorr_o),
    .n_corr_o(n_corr_o), .fmt_err_o(fmt_err_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int errors  = 0;
  int fmt_cnt = 0;

  always @(negedge clk_i) if (fmt_err_o) fmt_cnt++;

  logic [W-1:0] rx   [N];
  logic [W-1:0] expd [N];
  int ev_pos[$];
  int ev_y[$];
  bit ev_den[$];

  // Symbol s = c*M + m travels on lane M-1-m of beat c.
  function automatic logic [M*W-1:0] pack(input int b, input bit use_exp);
    logic [M*W-1:0] v;
    v = '0;
    for (int m = 0; m < M; m++)
      v[(M-1-m)*W +: W] = use_exp ? expd[b*M+m] : rx[b*M+m];
    return v;
  endfunction

  // Reference: apply the event list symbol by symbol to the received frame.
  task automatic model(input bit exceed, output bit unc, output int ncorr);
    int stored;
    stored = 0;
    unc = exceed;
    for (int s = 0; s < N; s++) expd[s] = rx[s];
    for (int i = 0; i < ev_pos.size(); i++) begin
      if (ev_den[i]) unc = 1;
      if (ev_pos[i] >= N) unc = 1;
      else if (stored == T) unc = 1;
      else begin
        stored++;
        expd[ev_pos[i]] = expd[ev_pos[i]] ^ W'(ev_y[i]);
      end
    end
    if (unc) for (int s = 0; s < N; s++) expd[s] = rx[s];
    ncorr = unc ? 0 : stored;
  endtask

  task automatic add_ev(input int pos, input int y, input bit den);
    ev_pos.push_back(pos);
    ev_y.push_back(y);
    ev_den.push_back(den);
  endtask

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if (out_valid_o !== 1'b0 || out_data_o !== '0 || out_start_o !== 1'b0 ||
        out_last_o !== 1'b0 || out_uncorr_o !== 1'b0 || n_corr_o !== 4'd0 ||
        fny_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: valid=%b start=%b last=%b uncorr=%b ncorr=%0d fny_rdy=%b data_nonzero=%b, required all 0",
               tag, out_valid_o, out_start_o, out_last_o, out_uncorr_o, n_corr_o, fny_rdy_o, |out_data_o);
    end
  endtask

  // Loads a random frame, sends the queued events, then drains the output.
  task automatic run_frame(input string tag, input int last_beat, input bit exceed,
                           input bit done_with_last, input bit stall, input int abort_at);
    bit unc;
    int ncorr, b;
    for (int s = 0; s < N; s++) rx[s] = W'($urandom_range(0, 1023));
    for (int bb = 0; bb < CYCLES; bb++) begin
      @(negedge clk_i);
      vectors++;
      if (in_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL %s in_ready beat %0d: got %b, required 1", tag, bb, in_ready_o);
      end
      in_valid_i = 1'b1;
      in_start_i = (bb == 0);
      in_last_i  = (bb == last_beat);
      in_data_i  = pack(bb, 1'b0);
    end
    @(negedge clk_i);
    in_valid_i = 1'b0; in_start_i = 1'b0; in_last_i = 1'b0;
    vectors++;
    if (fny_rdy_o !== 1'b1 || in_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s corr entry: fny_rdy=%b in_ready=%b, required 1/0", tag, fny_rdy_o, in_ready_o);
    end
    if (exceed) begin
      exceed_i = 1'b1;
      @(negedge clk_i);
      exceed_i = 1'b0;
    end
    for (int i = 0; i < ev_pos.size(); i++) begin
      fny_vld_i      = 1'b1;
      fny_pos_i      = POS_W'(ev_pos[i]);
      fny_y_i        = W'(ev_y[i]);
      fny_den_zero_i = ev_den[i];
      done_i         = done_with_last && (i == ev_pos.size() - 1);
      @(negedge clk_i);
    end
    fny_vld_i = 1'b0; fny_den_zero_i = 1'b0;
    if (!(done_with_last && ev_pos.size() > 0)) begin
      done_i = 1'b1;
      @(negedge clk_i);
    end
    done_i = 1'b0;
    model(exceed, unc, ncorr);

    b = 0;
    vectors++;
    if (out_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL %s out latency: out_valid=%b the cycle after done, required 1", tag, out_valid_o);
    end
    for (int cyc = 0; cyc < 120 && b < CYCLES; cyc++) begin
      if (b == abort_at) begin
        rst_ni = 1'b0;
        #1;
        check_idle_outputs({tag, " async reset"});
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_idle_outputs({tag, " after reset"});
        vectors++;
        if (in_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL %s after reset in_ready: got %b, required 1", tag, in_ready_o);
        end
        return;
      end
      out_ready_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      vectors++;
      if (out_valid_o !== 1'b1 || out_data_o !== pack(b, 1'b1) ||
          out_start_o !== (b == 0) || out_last_o !== (b == CYCLES-1) ||
          out_uncorr_o !== unc || n_corr_o !== 4'(ncorr)) begin
        errors++;
        $display("FAIL %s beat %0d: valid=%b start=%b last=%b uncorr=%b ncorr=%0d data=%h, required 1/%b/%b/%b/%0d data=%h",
                 tag, b, out_valid_o, out_start_o, out_last_o, out_uncorr_o, n_corr_o,
                 out_data_o[63:0], b == 0, b == CYCLES-1, unc, ncorr, pack(b, 1'b1) >> 0 & 64'hFFFF_FFFF_FFFF_FFFF);
      end
      if (out_ready_i && out_valid_o) b++;
      @(negedge clk_i);
    end
    out_ready_i = 1'b1;
    vectors++;
    if (b != CYCLES || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s frame end: handshakes=%0d valid=%b in_ready=%b, required 17/0/1",
               tag, b, out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_reset();
    #12;
    check_idle_outputs("reset held");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check_idle_outputs("reset released");
    vectors++;
    if (in_ready_o !== 1'b1 || fmt_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset ready: in_ready=%b fmt_err=%b, required 1/0", in_ready_o, fmt_err_o);
    end
  endtask

  task automatic test_clean();
    int f0;
    f0 = fmt_cnt;
    ev_pos.delete(); ev_y.delete(); ev_den.delete();
    run_frame("clean", CYCLES-1, 0, 0, 0, -1);
    vectors++;
    if (fmt_cnt != f0) begin
      errors++;
      $display("FAIL clean fmt_err: %0d pulses, required 0", fmt_cnt - f0);
    end
  endtask

  task automatic test_three_errors();
    ev_pos.delete(); ev_y.delete(); ev_den.delete();
    add_ev(0, 'h155, 0);
    add_ev(31, 'h001, 0);
    add_ev(543, 'h3FF, 0);
    run_frame("three_errors", CYCLES-1, 0, 0, 0, -1);
  endtask

  task automatic test_random_correctable();
    for (int k = 0; k < 4; k++) begin
      ev_pos.delete(); ev_y.delete(); ev_den.delete();
      repeat ($urandom_range(1, T)) add_ev($urandom_range(0, N-1), $urandom_range(0, 1023), 0);
      // k==3 forces two hits on one symbol to exercise XOR accumulation
      if (k == 3) begin
        add_ev(100, 'h0F0, 0);
        if (ev_pos.size() > T) void'(ev_pos.pop_front());
        if (ev_y.size() > ev_pos.size()) void'(ev_y.pop_front());
        if (ev_den.size() > ev_pos.size()) void'(ev_den.pop_front());
        ev_pos[0] = 100;
      end
      run_frame("random_corr", CYCLES-1, 0, 0, 0, -1);
    end
  endtask

  task automatic test_uncorrectable();
    ev_pos.delete(); ev_y.delete(); ev_den.delete();
    repeat (T + 1) add_ev($urandom_range(0, N-1), $urandom_range(1, 1023), 0);
    run_frame("overflow", CYCLES-1, 0, 0, 0, -1);

    ev_pos.delete(); ev_y.delete(); ev_den.delete();
    add_ev($urandom_range(0, N-1), $urandom_range(1, 1023), 0);
    run_frame("exceed", CYCLES-1, 1, 0, 0, -1);

    ev_pos.delete(); ev_y.delete(); ev_den.delete();
    add_ev(10, 'h0AA, 0);
    add_ev(200, 'h155, 1);
    run_frame("den_zero", CYCLES-1, 0, 0, 0, -1);

    ev_pos.delete(); ev_y.delete(); ev_den.delete();
    add_ev(5, 'h011, 0);
    add_ev(600, 'h022, 0);
    run_frame("bad_pos", CYCLES-1, 0, 0, 0, -1);
  endtask

  task automatic test_stall();
    ev_pos.delete(); ev_y.delete(); ev_den.delete();
    repeat (4) add_ev($urandom_range(0, N-1), $urandom_range(0, 1023), 0);
    run_frame("stall", CYCLES-1, 0, 0, 1, -1);
  endtask

  task automatic test_done_with_event_and_early_last();
    int f0;
    f0 = fmt_cnt;
    ev_pos.delete(); ev_y.delete(); ev_den.delete();
    add_ev(300, 'h2A5, 0);
    add_ev(543, 'h001, 0);
    run_frame("early_last", 10, 0, 1, 0, -1);
    vectors++;
    if (fmt_cnt - f0 != 1) begin
      errors++;
      $display("FAIL early_last fmt_err: %0d pulses, required 1", fmt_cnt - f0);
    end
  endtask

  task automatic test_fmt_idle();
    int f0;
    f0 = fmt_cnt;
    @(negedge clk_i);
    in_valid_i = 1'b1; in_start_i = 1'b0; in_data_i = '1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if (fmt_cnt - f0 != 1 || in_ready_o !== 1'b1 || fny_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: fmt pulses=%0d in_ready=%b fny_rdy=%b, required 1/1/0",
               fmt_cnt - f0, in_ready_o, fny_rdy_o);
    end
  endtask

  task automatic test_reset_mid_out();
    ev_pos.delete(); ev_y.delete(); ev_den.delete();
    add_ev(20, 'h3C3, 0);
    run_frame("reset_mid", CYCLES-1, 0, 0, 0, 8);
    ev_pos.delete(); ev_y.delete(); ev_den.delete();
    add_ev(270, 'h111, 0);
    add_ev(271, 'h222, 0);
    run_frame("post_reset", CYCLES-1, 0, 0, 0, -1);
  endtask

  initial begin
    test_reset();
    test_clean();
    test_three_errors();
    test_random_correctable();
    test_uncorrectable();
    test_stall();
    test_done_with_event_and_early_last();
    test_fmt_idle();
    test_reset_mid_out();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
